// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and helpers for the simple-dual-port RAM controller.
package sdp_ram_pkg;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} init_state_e;

   function automatic int lanes_of(input int data_width);
      return data_width / 8;
   endfunction

   // Even parity: the stored bit makes the 9-bit lane carry an even number of ones.
   function automatic logic lane_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sdp_ram_ctrl_if.sv
// sdp_ram_ctrl_if: write/read port bundle; par_inj exists only when SDP_RAM_PARITY_EN is defined.
interface sdp_ram_ctrl_if
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
);
   localparam int LANES = lanes_of(DATA_WIDTH);

   logic [ADDR_WIDTH-1:0] addra;
   logic [DATA_WIDTH-1:0] dina;
   logic [LANES-1:0]      wea;
   logic [ADDR_WIDTH-1:0] addrb;
   logic                  enb;
   logic [DATA_WIDTH-1:0] doutb;
   logic                  doutb_valid;
   logic                  init_busy;
   logic                  par_err;
`ifdef SDP_RAM_PARITY_EN
   logic [LANES-1:0]      par_inj;
`endif

   modport master (
`ifdef SDP_RAM_PARITY_EN
      output par_inj,
`endif
      output addra, dina, wea, addrb, enb,
      input  doutb, doutb_valid, init_busy, par_err
   );

   modport slave (
`ifdef SDP_RAM_PARITY_EN
      input  par_inj,
`endif
      input  addra, dina, wea, addrb, enb,
      output doutb, doutb_valid, init_busy, par_err
   );
endinterface

// File: rtl/sdp_ram_bank.sv
// sdp_ram_bank: plain lane-enabled storage array with a registered, unreset read port.
module sdp_ram_bank #(
   parameter int ADDR_WIDTH = 14,
   parameter int LANES      = 4,
   parameter int LANE_W     = 8
) (
   input  logic                          clka,
   input  logic [ADDR_WIDTH-1:0]         waddr,
   input  logic [LANES-1:0][LANE_W-1:0]  wdata,
   input  logic [LANES-1:0]              wen,
   input  logic [ADDR_WIDTH-1:0]         raddr,
   input  logic                          ren,
   output logic [LANES-1:0][LANE_W-1:0]  rdata
);
   logic [LANES-1:0][LANE_W-1:0] mem [2**ADDR_WIDTH];

   // Read-before-write on the same edge; the controller merges new lanes itself.
   always_ff @(posedge clka) begin
      for (int i = 0; i < LANES; i++)
         if (wen[i]) mem[waddr][i] <= wdata[i];
      if (ren) rdata <= mem[raddr];
   end
endmodule

// File: rtl/sdp_ram_ctrl.sv
// sdp_ram_ctrl: SDP RAM with post-reset clear, 1/2-cycle read pipeline and write-first bypass.
// Define SDP_RAM_PARITY_EN to store and check one even-parity bit per byte lane.
module sdp_ram_ctrl
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input logic           clka,
   input logic           rsta,
   sdp_ram_ctrl_if.slave bus
);
   localparam int LANES  = lanes_of(DATA_WIDTH);
`ifdef SDP_RAM_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

   init_state_e                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]        cnt, wr_addr;
   logic                         busy, acc, rd_err;
   logic [LANES-1:0]             wr_en, byp_mask;
   logic [LANES-1:0][LANE_W-1:0] wr_word, rd_word;
   logic [LANES-1:0][7:0]        din, byp_data, merged;
   logic [STAGES:1]              vld_q;
   logic [STAGES:0]              vld_pipe;
   logic [DATA_WIDTH-1:0]        dout;
   logic                         perr;

   assign din = bus.dina;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state <= (INIT_CLEAR != 0) ? CLEAR : READY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && &cnt) state_nxt = READY;
   end

   // The clear sequence owns the write port while busy; user writes are dropped.
   always_comb begin
      busy    = (state == CLEAR);
      wr_addr = busy ? cnt : bus.addra;
      wr_en   = busy ? '1 : bus.wea;
      wr_word = '0;
      if (!busy)
         for (int i = 0; i < LANES; i++) begin
`ifdef SDP_RAM_PARITY_EN
            wr_word[i] = {lane_par(din[i]) ^ bus.par_inj[i], din[i]};
`else
            wr_word[i] = din[i];
`endif
         end
   end

   assign acc = bus.enb & ~busy;

   sdp_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH), .LANES(LANES), .LANE_W(LANE_W)) u_bank (
      .clka  (clka),
      .waddr (wr_addr),
      .wdata (wr_word),
      .wen   (wr_en),
      .raddr (bus.addrb),
      .ren   (acc),
      .rdata (rd_word)
   );

   // Bypass state only moves on an accepted read so it stays paired with rd_word.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         vld_q    <= '0;
         byp_mask <= '0;
         byp_data <= '0;
      end else begin
         vld_q <= vld_pipe[STAGES-1:0];
         if (acc) begin
            byp_mask <= (bus.addra == bus.addrb) ? bus.wea : '0;
            byp_data <= din;
         end
      end
   end

   assign vld_pipe = {vld_q, acc};

   always_comb begin
      merged = '0;
      rd_err = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         merged[i] = byp_mask[i] ? byp_data[i] : rd_word[i][7:0];
`ifdef SDP_RAM_PARITY_EN
         if (!byp_mask[i] && (lane_par(rd_word[i][7:0]) != rd_word[i][8])) rd_err = 1'b1;
`endif
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         always_ff @(posedge clka or posedge rsta) begin
            if (rsta) begin
               dout <= '0;
               perr <= 1'b0;
            end else begin
               if (vld_pipe[1]) dout <= merged;
               perr <= vld_pipe[1] & rd_err;
            end
         end
      end else begin : g_ocomb
         // Unreset bank output is masked until the first read lands.
         logic has_data;
         always_ff @(posedge clka or posedge rsta) begin
            if (rsta) has_data <= 1'b0;
            else      has_data <= has_data | acc;
         end
         assign dout = has_data ? merged : '0;
         assign perr = vld_pipe[1] & rd_err;
      end
   endgenerate

   assign bus.doutb       = dout;
   assign bus.doutb_valid = vld_pipe[STAGES];
   assign bus.init_busy   = busy;
   assign bus.par_err     = perr;
endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// tb_sdp_ram_ctrl: drives OUT_REG=0 and OUT_REG=1 instances with identical stimulus; a scoreboard
// of expected reads (data, parity flag, arrival cycle) is checked by a separate monitor.
module tb_sdp_ram_ctrl;
   localparam int AW = 4, DW = 32, DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      logic        perr;
      int          due;
   } sb_t;

   logic        clk = 1'b0;
   logic        rsta = 1'b1;
   int          cyc = 0, errors = 0, checks = 0, busy_left = 0;
   logic [31:0] mem [DEPTH];
   logic [3:0]  bad [DEPTH];
   logic [31:0] last [2];
   sb_t         q0[$], q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdp_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   sdp_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   assign bus1.addra = bus0.addra;
   assign bus1.dina  = bus0.dina;
   assign bus1.wea   = bus0.wea;
   assign bus1.addrb = bus0.addrb;
   assign bus1.enb   = bus0.enb;
`ifdef SDP_RAM_PARITY_EN
   assign bus1.par_inj = bus0.par_inj;
`endif

   sdp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
      .clka(clk), .rsta(rsta), .bus(bus0.slave));
   sdp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
      .clka(clk), .rsta(rsta), .bus(bus1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic [31:0] d, input logic pe);
      sb_t it;
      if (v) begin
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: doutb_valid=1 with no read outstanding (cycle %0d)", k, cyc);
         end else begin
            it = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rd_data dut%0d", k), d, it.data);
            chk($sformatf("par_err dut%0d", k), 32'(pe), 32'(it.perr));
            chk($sformatf("latency dut%0d", k), cyc, it.due);
         end
         last[k] = d;
      end else begin
         chk($sformatf("hold dut%0d", k), d, last[k]);
         chk($sformatf("par_err_idle dut%0d", k), 32'(pe), 32'h0);
      end
   endtask

   always @(negedge clk) begin
      if (rsta) begin
         last[0] = '0;
         last[1] = '0;
      end else begin
         mon(0, bus0.doutb_valid, bus0.doutb, bus0.par_err);
         mon(1, bus1.doutb_valid, bus1.doutb, bus1.par_err);
      end
   end

   task automatic drive_idle();
      bus0.addra = '0; bus0.dina = '0; bus0.wea = '0; bus0.addrb = '0; bus0.enb = 1'b0;
`ifdef SDP_RAM_PARITY_EN
      bus0.par_inj = '0;
`endif
   endtask

   // Called at a negedge: drive one cycle, predict its effect, advance to the next negedge.
   task automatic step(input logic [3:0] we, input logic [3:0] aa, input logic [31:0] d,
                       input logic re, input logic [3:0] ab, input logic [3:0] inj,
                       input bit use_c, input logic [31:0] cval);
      logic [31:0] w;
      logic [3:0]  fwd;
      logic        pe;
      chk("init_busy dut0", 32'(bus0.init_busy), 32'(busy_left > 0));
      chk("init_busy dut1", 32'(bus1.init_busy), 32'(busy_left > 0));
`ifdef SDP_RAM_PARITY_EN
      bus0.par_inj = inj;
`else
      inj = '0;
`endif
      bus0.wea = we; bus0.addra = aa; bus0.dina = d; bus0.enb = re; bus0.addrb = ab;
      if (busy_left > 0) busy_left--;
      else begin
         if (re) begin
            w   = mem[ab];
            fwd = (aa == ab) ? we : 4'h0;
            for (int i = 0; i < 4; i++) if (fwd[i]) w[8*i +: 8] = d[8*i +: 8];
            pe  = |(bad[ab] & ~fwd);
            q0.push_back('{use_c ? cval : w, pe, cyc + 1});
            q1.push_back('{use_c ? cval : w, pe, cyc + 2});
         end
         for (int i = 0; i < 4; i++)
            if (we[i]) begin
               mem[aa][8*i +: 8] = d[8*i +: 8];
               bad[aa][i] = inj[i];
            end
      end
      @(negedge clk);
   endtask

   task automatic rnd_step();
      logic [3:0] we, aa, ab, inj;
      we  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      aa  = 4'($urandom_range(0, 15));
      ab  = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(we, aa, $urandom, ($urandom_range(0, 3) != 0), ab, inj, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rsta = 1'b1;
      drive_idle();
      #1;
      chk("rst doutb dut0", bus0.doutb, 32'h0);
      chk("rst doutb dut1", bus1.doutb, 32'h0);
      chk("rst valid", 32'({bus0.doutb_valid, bus1.doutb_valid}), 32'h0);
      chk("rst par_err", 32'({bus0.par_err, bus1.par_err}), 32'h0);
      chk("rst init_busy", 32'({bus0.init_busy, bus1.init_busy}), 32'h3);
      @(negedge clk);
      @(negedge clk);
      rsta = 1'b0;
      busy_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) begin
         mem[a] = '0;
         bad[a] = '0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         step(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
         n++;
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d reads never returned, required 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      drive_idle();
      @(negedge clk);
      do_reset();
      repeat (DEPTH + 1) step(4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      for (int a = 0; a < DEPTH; a++) step(4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 4'h0, 1'b1, 32'h0);

      // byte lanes
      step(4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      step(4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      step(4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 4'h0, 1'b1, 32'hAA22CC44);
      // back-to-back reads
      for (int a = 0; a < 4; a++) step(4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 4'h0, 1'b0, 32'h0);
      // write-first collision
      step(4'hF, 4'd5, 32'h12345678, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      step(4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 4'h0, 1'b1, 32'h1234FFFF);
      // write right behind a read of the same address
      step(4'h0, 4'h0, 32'h0, 1'b1, 4'd6, 4'h0, 1'b0, 32'h0);
      step(4'hF, 4'd6, 32'hA5A5A5A5, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      step(4'h0, 4'h0, 32'h0, 1'b1, 4'd6, 4'h0, 1'b1, 32'hA5A5A5A5);
`ifdef SDP_RAM_PARITY_EN
      step(4'hF, 4'd9, 32'h000000FF, 1'b0, 4'h0, 4'b0001, 1'b0, 32'h0);
      step(4'h0, 4'h0, 32'h0, 1'b1, 4'd9, 4'h0, 1'b1, 32'h000000FF);
      step(4'hF, 4'd9, 32'h000000FF, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      step(4'h0, 4'h0, 32'h0, 1'b1, 4'd9, 4'h0, 1'b1, 32'h000000FF);
`endif
      repeat (400) rnd_step();
      drain();

      // reset at cnt=7, activity while busy must be ignored
      do_reset();
      repeat (7) rnd_step();
      do_reset();
      repeat (DEPTH) rnd_step();
      for (int a = 0; a < DEPTH; a++) step(4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 4'h0, 1'b1, 32'h0);
      repeat (150) rnd_step();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
